right_shift_pipe: RTL and testbench
===================================

// Module: right_shift_pipe
// PURPOSE
//  Pipelined 32-bit right shifter (logical SRL / arithmetic SRA) for the execute stage.
//  Complements the combinational left barrel shifter; the ALU routes sll there and srl/sra here.
//  Two register stages with valid/ready handshake on both sides, one op/cycle throughput.
//  A destination tag rides alongside; flush kills in-flight ops on a branch mispredict.
// PARAMETERS
//  WIDTH    32  data width; power of two
//  SHAMT_W  5   shift-amount width; must equal log2(WIDTH)
//  TAG_W    5   sideband tag width (destination register index)
// PORTS
//  clock      in   1        rising-edge clock
//  reset      in   1        asynchronous, active-low reset
//  flush      in   1        sync kill of all in-flight ops
//  in_valid   in   1        input op valid
//  in_ready   out  1        shifter can accept this cycle
//  in_data    in   WIDTH    operand A
//  in_shamt   in   SHAMT_W  shift amount, 0..WIDTH-1
//  in_arith   in   1        1 = SRA (sign fill), 0 = SRL (zero fill)
//  in_tag     in   TAG_W    sideband, returned unchanged
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  out_data   out  WIDTH    shifted result
//  out_tag    out  TAG_W    tag of the op in out_data
// BEHAVIOUR
//  - Reset (reset=0, async): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_tag=0;
//    in_ready=1 when reset deasserts.
//  - Transfer on a side when valid && ready both high at a rising clock edge.
//  - Stage 1: shifts by shamt[4] (16) and shamt[3] (8); registers partial result,
//    shamt[2:0], arith, tag, s1_valid.
//  - Stage 2: shifts by 4/2/1 from the registered shamt bits; registers out_data/out_tag/out_valid.
//  - Fill bit = arith ? in_data[WIDTH-1] : 0. Captured at stage 1 and reused in stage 2.
//  - Latency: result is visible 2 cycles after input acceptance, with out_valid=1.
//  - Ready chain: s2_ready = !out_valid || out_ready; s1_ready = !s1_valid || s2_ready;
//    in_ready = s1_ready && !flush. Combinational, with no loop through in_valid.
//  - Stall: while out_valid && !out_ready, out_data/out_tag stay stable and stage 2 holds.
//    Stage 1 holds if it is full. At most 2 ops are held; in_ready then drops.
//  - Simultaneous push + pop on a full pipe: both proceed; occupancy is unchanged.
//  - flush=1: s1_valid and out_valid clear at the next edge. No input is accepted that cycle.
//    Data registers are don't-care after flush. flush overrides out_ready.
//  - Reset mid-operation: all valids clear immediately; in-flight ops are lost, no partial output.
//  - shamt=0 passes data through unchanged; order is strictly preserved (FIFO).
// STRUCTURE
//  - Shared defines header: SHIFT_SRL=0 / SHIFT_SRA=1 opcode constants, used by the ALU decode.
//  - One sub-module, rshift_stage (params WIDTH, AMT):
//    out = sel ? {{AMT{fill}}, in[WIDTH-1:AMT]} : in.
//    Built on the existing twoToOneMux; instantiated 5x (16, 8 | 4, 2, 1).
//  - Top level holds only the pipeline registers, the valid bits and the ready logic.
// TESTING
//  1. Reset asserted mid-stream, then released -> out_valid=0, out_data=0, in_ready=1 with no stray output.
//  2. SRL 0x80000000 >>31 -> 0x00000001; SRL 0xF0F0F0F0 >>4 -> 0x0F0F0F0F,
//     out_valid exactly 2 cycles after accept.
//  3. SRA 0x80000000 >>4 -> 0xF8000000; SRA 0x7FFFFFF0 >>4 -> 0x07FFFFFF;
//     SRA 0xFFFFFFFF >>31 -> 0xFFFFFFFF.
//  4. Back-to-back tags 1,2,3 with shamt 0/1/2 on 0x00000008 -> 0x8, 0x4, 0x2 on 3 consecutive cycles, tags in order.
//  5. out_ready=0 for 4 cycles while 3 ops are offered -> 2 accepted, in_ready=0, out_data held stable;
//     release -> all 3 drain in order.
//  6. flush with 2 ops in flight and in_valid=1 -> out_valid=0 next cycle, input not accepted,
//     the next op flows normally.

Source files
------------

// File: rtl/right_shift_pipe_pkg.sv
// Shared constants and helpers for the pipelined right shifter.
// Opcode encodings are also consumed by the ALU decode.
package right_shift_pipe_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;
  localparam int DEF_TAG_W   = 5;

  localparam logic SHIFT_SRL = 1'b0;
  localparam logic SHIFT_SRA = 1'b1;

  function automatic logic fill_bit(
    input logic arith,
    input logic msb
  );
    return (arith == SHIFT_SRA) ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/right_shift_pipe_rshift_stage.sv
// One fixed-distance right-shift step of the barrel.
// Passes the input through when not selected.
module rshift_stage #(
  parameter int WIDTH = 32,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_sel,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_shift;

  assign w_shift = {{AMT{i_fill}}, i_data[WIDTH-1:AMT]};
  assign o_data  = i_sel ? w_shift : i_data;

endmodule

// File: rtl/right_shift_pipe.sv
// Two-stage SRL/SRA shifter with valid/ready on both sides.
// Stage 1 does 16/8, stage 2 does 4/2/1; tag rides along.
module right_shift_pipe
  import right_shift_pipe_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_arith,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic [2:0]       r_s1_shamt;
  logic             r_s1_fill;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [TAG_W-1:0] r_out_tag;

  logic             w_s2_ready;
  logic             w_s1_ready;
  logic             w_accept;
  logic             w_advance;
  logic             w_fill;
  logic [WIDTH-1:0] w_sh16;
  logic [WIDTH-1:0] w_sh8;
  logic [WIDTH-1:0] w_sh4;
  logic [WIDTH-1:0] w_sh2;
  logic [WIDTH-1:0] w_sh1;

  assign w_s2_ready = !r_out_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign in_ready   = w_s1_ready && !flush;
  assign w_accept   = in_valid && in_ready;
  assign w_advance  = r_s1_valid && w_s2_ready;
  assign w_fill     = fill_bit(in_arith, in_data[WIDTH-1]);

  rshift_stage #(.WIDTH(WIDTH), .AMT(16)) u_sh16 (
    .i_data (in_data),
    .i_sel  (in_shamt[SHAMT_W-1]),
    .i_fill (w_fill),
    .o_data (w_sh16)
  );

  rshift_stage #(.WIDTH(WIDTH), .AMT(8)) u_sh8 (
    .i_data (w_sh16),
    .i_sel  (in_shamt[SHAMT_W-2]),
    .i_fill (w_fill),
    .o_data (w_sh8)
  );

  rshift_stage #(.WIDTH(WIDTH), .AMT(4)) u_sh4 (
    .i_data (r_s1_data),
    .i_sel  (r_s1_shamt[2]),
    .i_fill (r_s1_fill),
    .o_data (w_sh4)
  );

  rshift_stage #(.WIDTH(WIDTH), .AMT(2)) u_sh2 (
    .i_data (w_sh4),
    .i_sel  (r_s1_shamt[1]),
    .i_fill (r_s1_fill),
    .o_data (w_sh2)
  );

  rshift_stage #(.WIDTH(WIDTH), .AMT(1)) u_sh1 (
    .i_data (w_sh2),
    .i_sel  (r_s1_shamt[0]),
    .i_fill (r_s1_fill),
    .o_data (w_sh1)
  );

  // Stage 1: capture coarse-shifted operand when an op is accepted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_shamt <= '0;
      r_s1_fill  <= 1'b0;
      r_s1_tag   <= '0;
    end else begin
      if (flush) begin
        r_s1_valid <= 1'b0;
      end else if (w_s1_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_accept) begin
        r_s1_data  <= w_sh8;
        r_s1_shamt <= in_shamt[2:0];
        r_s1_fill  <= w_fill;
        r_s1_tag   <= in_tag;
      end
    end
  end

  // Stage 2: finish the shift and hold the result until consumed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_s2_ready) begin
        r_out_valid <= r_s1_valid;
      end
      if (w_advance) begin
        r_out_data <= w_sh1;
        r_out_tag  <= r_s1_tag;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_right_shift_pipe.sv
// Directed bench for right_shift_pipe: vector table
// plus stall, flush and reset sequences.
module tb_right_shift_pipe;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        in_arith;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  int checks;
  int failures;
  int acc_cnt;
  logic last_acc;

  logic [31:0] q_data[$];
  logic [4:0]  q_tag[$];

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic        arith;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  right_shift_pipe dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_arith  (in_arith),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    #1;
    last_acc = in_valid && in_ready && reset;
    if (last_acc) acc_cnt++;
    if (out_valid && out_ready && reset) begin
      q_data.push_back(out_data);
      q_tag.push_back(out_tag);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d,
                       input logic [4:0] s, input logic a,
                       input logic [4:0] t);
    in_valid = v;
    in_data  = d;
    in_shamt = s;
    in_arith = a;
    in_tag   = t;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    acc_cnt  = 0;
    last_acc = 1'b0;

    vecs[0]  = '{32'h80000000, 5'd31, 1'b0, 5'd1,  32'h00000001};
    vecs[1]  = '{32'hF0F0F0F0, 5'd4,  1'b0, 5'd2,  32'h0F0F0F0F};
    vecs[2]  = '{32'h80000000, 5'd4,  1'b1, 5'd3,  32'hF8000000};
    vecs[3]  = '{32'h7FFFFFF0, 5'd4,  1'b1, 5'd4,  32'h07FFFFFF};
    vecs[4]  = '{32'hFFFFFFFF, 5'd31, 1'b1, 5'd5,  32'hFFFFFFFF};
    vecs[5]  = '{32'hDEADBEEF, 5'd0,  1'b1, 5'd6,  32'hDEADBEEF};
    vecs[6]  = '{32'hFFFFFFFF, 5'd16, 1'b0, 5'd7,  32'h0000FFFF};
    vecs[7]  = '{32'h12345678, 5'd12, 1'b0, 5'd8,  32'h00012345};
    vecs[8]  = '{32'h89ABCDEF, 5'd8,  1'b1, 5'd9,  32'hFF89ABCD};
    vecs[9]  = '{32'h89ABCDEF, 5'd8,  1'b0, 5'd10, 32'h0089ABCD};
    vecs[10] = '{32'hF0F0F0F0, 5'd20, 1'b1, 5'd11, 32'hFFFFFF0F};
    vecs[11] = '{32'hA5A5A5A5, 5'd1,  1'b0, 5'd31, 32'h52D2D2D2};

    reset     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // reset asserted mid-stream
    drive(1'b1, 32'h11110000, 5'd0, 1'b0, 5'd12);
    tick();
    drive(1'b1, 32'h22220000, 5'd0, 1'b0, 5'd13);
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_valid_now", {31'd0, out_valid}, 32'd0);
    drive(1'b0, '0, '0, 1'b0, '0);
    tick();
    reset = 1'b1;
    q_data.delete();
    q_tag.delete();
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_data", out_data, 32'd0);
    repeat (3) tick();
    chk("midrst_no_stray", q_data.size(), 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);

    // vector table, one op at a time, latency checked
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].data, vecs[i].shamt, vecs[i].arith,
            vecs[i].tag);
      tick();
      chk($sformatf("vec%0d_accept", i), {31'd0, last_acc}, 32'd1);
      chk($sformatf("vec%0d_lat1", i), {31'd0, out_valid}, 32'd0);
      drive(1'b0, '0, '0, 1'b0, '0);
      tick();
      chk($sformatf("vec%0d_lat2", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      chk($sformatf("vec%0d_tag", i), {27'd0, out_tag},
          {27'd0, vecs[i].tag});
      tick();
    end

    // back-to-back ops
    drive(1'b1, 32'h8, 5'd0, 1'b0, 5'd1);
    tick();
    drive(1'b1, 32'h8, 5'd1, 1'b0, 5'd2);
    tick();
    chk("b2b_v0", {31'd0, out_valid}, 32'd1);
    chk("b2b_d0", out_data, 32'h8);
    chk("b2b_t0", {27'd0, out_tag}, 32'd1);
    drive(1'b1, 32'h8, 5'd2, 1'b0, 5'd3);
    tick();
    chk("b2b_d1", out_data, 32'h4);
    chk("b2b_t1", {27'd0, out_tag}, 32'd2);
    drive(1'b0, '0, '0, 1'b0, '0);
    tick();
    chk("b2b_v2", {31'd0, out_valid}, 32'd1);
    chk("b2b_d2", out_data, 32'h2);
    chk("b2b_t2", {27'd0, out_tag}, 32'd3);
    tick();
    chk("b2b_empty", {31'd0, out_valid}, 32'd0);

    // stall with three ops offered
    q_data.delete();
    q_tag.delete();
    out_ready = 1'b0;
    acc_cnt   = 0;
    drive(1'b1, 32'h100, 5'd0, 1'b0, 5'd4);
    tick();
    drive(1'b1, 32'h100, 5'd4, 1'b0, 5'd5);
    tick();
    drive(1'b1, 32'h100, 5'd8, 1'b0, 5'd6);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("stall_hold_d%0d", i), out_data, 32'h100);
      chk($sformatf("stall_hold_t%0d", i), {27'd0, out_tag}, 32'd4);
    end
    chk("stall_accepted", acc_cnt, 32'd2);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && acc_cnt < 3; i++) tick();
    chk("stall_c_accepted", acc_cnt, 32'd3);
    drive(1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 10 && q_data.size() < 3; i++) tick();
    chk("stall_drain_cnt", q_data.size(), 32'd3);
    if (q_data.size() == 3) begin
      chk("stall_q0", q_data[0], 32'h100);
      chk("stall_q1", q_data[1], 32'h10);
      chk("stall_q2", q_data[2], 32'h1);
      chk("stall_t0", {27'd0, q_tag[0]}, 32'd4);
      chk("stall_t1", {27'd0, q_tag[1]}, 32'd5);
      chk("stall_t2", {27'd0, q_tag[2]}, 32'd6);
    end

    // flush with two ops in flight
    q_data.delete();
    q_tag.delete();
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA0000, 5'd0, 1'b0, 5'd20);
    tick();
    drive(1'b1, 32'hBBBB0000, 5'd0, 1'b0, 5'd21);
    tick();
    chk("fl_pre_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    drive(1'b1, 32'hCCCC0000, 5'd0, 1'b0, 5'd22);
    #1;
    chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("fl_not_acc", {31'd0, last_acc}, 32'd0);
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0);
    tick();
    tick();
    chk("fl_no_stray", q_data.size(), 32'd0);
    drive(1'b1, 32'h0000F000, 5'd12, 1'b0, 5'd23);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0);
    tick();
    chk("fl_next_valid", {31'd0, out_valid}, 32'd1);
    chk("fl_next_data", out_data, 32'hF);
    chk("fl_next_tag", {27'd0, out_tag}, 32'd23);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
